// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants for the FIFO write-side arbiter: beat width, burst default
// and the two arbiter state encodings.
package fifo_write_arbiter_pkg;

   localparam int FWA_DATA_WIDTH = 8;
   localparam int FWA_MAX_BURST  = 4;

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: first set request bit at or above rr_ptr,
// wrapping at NUM_REQ, returned both one-hot and as an index.
module rr_priority_select #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] request,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   index,
   output logic               found
);

   int               pos;
   logic [IDX_W-1:0] idx;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      pos    = 0;
      idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(rr_ptr) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = IDX_W'(pos);
         if (!found && request[idx]) begin
            found       = 1'b1;
            index       = idx;
            onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ producers,
// throttled on full/almost-full so the FIFO is never written while full.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = FWA_DATA_WIDTH,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = FWA_MAX_BURST
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            request,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
   input  logic                          fifo_full,
   input  logic                          fifo_almost_full,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          write_enable,
   output logic [DATA_WIDTH-1:0]         data,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [0:0]            state;
   logic [IDX_W-1:0]      rr_ptr;
   logic [3:0]            beat_cnt;
   logic [NUM_REQ-1:0]    arb_onehot;
   logic [IDX_W-1:0]      arb_index;
   logic                  arb_found;
   logic                  stall;
   logic                  accept;
   logic [IDX_W-1:0]      sel_idx;
   logic [DATA_WIDTH-1:0] sel_data;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
   endfunction

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_select (
      .request (request),
      .rr_ptr  (rr_ptr),
      .onehot  (arb_onehot),
      .index   (arb_index),
      .found   (arb_found)
   );

   assign stall = fifo_full | fifo_almost_full;
   assign busy  = (state == ST_BURST);

   // Almost-full gating leaves room for the one beat already sitting in the output register.
   always_comb begin
      grant   = '0;
      accept  = 1'b0;
      sel_idx = owner;
      if (!reset && !stall) begin
         if (state == ST_ARB) begin
            if (arb_found) begin
               grant   = arb_onehot;
               accept  = 1'b1;
               sel_idx = arb_index;
            end
         end else if (request[owner]) begin
            grant[owner] = 1'b1;
            accept       = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(sel_idx) == i) sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_ARB;
         rr_ptr       <= '0;
         owner        <= '0;
         beat_cnt     <= '0;
         write_enable <= 1'b0;
         data         <= '0;
      end else begin
         write_enable <= accept;
         if (accept) data <= sel_data;
         if (state == ST_ARB) begin
            if (accept) begin
               owner    <= arb_index;
               beat_cnt <= 4'd1;
               if (MAX_BURST == 1) rr_ptr <= wrap_inc(arb_index);
               else                state  <= ST_BURST;
            end
         end else begin
            // Stalled cycles neither count nor end the burst; only a dropped request does.
            if (accept) beat_cnt <= beat_cnt + 4'd1;
            if ((accept && (beat_cnt + 4'd1 == 4'(MAX_BURST))) || !request[owner]) begin
               state  <= ST_ARB;
               rr_ptr <= wrap_inc(owner);
            end
         end
      end
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin burst arbiter that shares the single write port of the asynchronous FIFO among `NUM_REQ` producers in the write-clock domain. It sequences producer beats into registered `write_enable`/`data` FIFO inputs and throttles on FIFO full and almost-full flags, so the FIFO is never written while full. The block sits between the producer blocks and the FIFO write side, clocked by the FIFO write clock.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH macro (8): width of one data beat.
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `MAX_BURST`, default 4: maximum accepted beats per grant before rotation, range 1..15.
- `clock`  in  1: write-domain clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `request`  in  NUM_REQ: bit i set means requester i offers a beat on its data slice.
- `data_in`  in  NUM_REQ*DATA_WIDTH: packed request data; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `fifo_full`  in  1: FIFO full flag, write-domain synchronized.
- `fifo_almost_full`  in  1: asserted when at most one free FIFO slot remains.
- `grant`  out  NUM_REQ: one-hot or zero; bit i means requester i's beat is accepted this cycle.
- `write_enable`  out  1: registered FIFO write strobe.
- `data`  out  DATA_WIDTH: registered FIFO write data.
- `owner`  out  clog2(NUM_REQ): current or last burst owner.
- `busy`  out  1: high in BURST state.

## Operation
- `stall = fifo_full | fifo_almost_full`. No beat is accepted while stall is high.
- Two-state FSM:
  - ARB: if `!stall` and any `request` bit is set, the winner is the first set bit searching upward from `rr_ptr`, wrapping at NUM_REQ. `grant[winner]=1` the same cycle and the beat is accepted. `owner<=winner` and `beat_cnt<=1`. Next state is BURST unless MAX_BURST==1, in which case it stays ARB with `rr_ptr<=winner+1` (mod NUM_REQ).
  - BURST: `grant[owner] = request[owner] & !stall`. Each accepted beat does `beat_cnt+1`.
  - Exit BURST to ARB when an accepted beat brings `beat_cnt` to MAX_BURST, or when `request[owner]==0`. On exit, `rr_ptr<=owner+1` (mod NUM_REQ).
  - Stall cycles in BURST do not count and do not end the burst, unless the owner drops `request`.
- Requester handshake: hold `request` and the data slice stable until `grant` is seen. The beat is consumed on the cycle `grant` is high. The next beat may be presented on the following cycle.
- An accepted beat produces `write_enable<=1` and `data<=selected slice` on the next edge. Otherwise `write_enable<=0` and `data` holds.
- At most one grant bit is high per cycle. `grant` is all zero during reset and in any stall cycle.

## Timing
- Latency: beat accepted at edge N produces `write_enable`/`data` valid in cycle N+1, i.e. one clock.
- Throughput: one beat per clock when not stalled, including across an ARB re-arbitration cycle.
- Reset values: state ARB, `rr_ptr=0`, `owner=0`, `beat_cnt=0`, `write_enable=0`, `data=0`, `busy=0`. `grant=0` while `reset` is high.
- Reset mid-burst takes effect at the next edge. Any pending registered write is dropped: `write_enable=0` after that edge.
- Almost-full margin: one beat may be in flight in the output register when the full flag rises. Gating on almost-full guarantees the FIFO is never written while full.
- Simultaneous requests in ARB are resolved purely by `rr_ptr`. A new higher-priority request never preempts a burst in progress.

## Structure
- Shared package/header holds `DATA_WIDTH`, the `ARB`/`BURST` state encodings and the `MAX_BURST` default, alongside the existing FIFO macros.
- One sub-module, `rr_priority_select`: combinational round-robin search taking `request` and `rr_ptr` and returning a one-hot result plus the index. The FSM, counters and output registers live in the top module.

## Test plan
- Reset: hold `reset` high for 3 cycles with all requests high -> `grant=0`, `write_enable=0`, `data=0`, `owner=0`, `busy=0`.
- Single requester: `request=4'b0010` with `data_in` slice 1 incrementing 0x10..0x15 and MAX_BURST=4 -> 4 grants to requester 1, one ARB cycle, 2 more grants. FIFO sees 0x10..0x15 in order, each one cycle after its grant.
- Round robin: all 4 requesters continuously high, MAX_BURST=2 -> grant bursts ordered 0,0,1,1,2,2,3,3,0,0, with no idle cycle between beats.
- Stall: in mid-burst with `beat_cnt=2`, assert `fifo_almost_full` for 5 cycles -> `grant=0` and `write_enable=0` from the next cycle, owner unchanged. After release, exactly 2 more beats before rotation.
- Early release: owner 2 drops `request` after 1 beat while requesters 0 and 3 wait -> ARB grants 3 next, since `rr_ptr=3`.
- Reset mid-burst: assert `reset` for 1 cycle during a burst -> all outputs return to reset values, and the next grant goes to the lowest requesting index from `rr_ptr=0`.
